// File: rtl/rng_health_monitor.sv
`default_nettype none
// ============================================================================
// rng_health_monitor -- repetition/proportion health tests on RNG samples,
//   gating healthy samples into a first-word-fall-through output FIFO.
//   Proportion test is built only when RNG_HEALTH_APT_EN is defined.
// Revision: 1.0
// ============================================================================
module rng_health_monitor #(
  parameter int DW         = 16,
  parameter int RCT_CUTOFF = 4,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 8,
  parameter int WARMUP_N   = 4,
  parameter int DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          clear_alarm,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          alarm_rct,
  output logic          alarm_apt,
  output logic [7:0]    drop_cnt,
  output logic [1:0]    state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(WARMUP_N + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t cur_state, nxt_state;

  logic          load_ref, run_step, clr_cnt, push_req, warm_inc;
  logic          rct_fail, apt_fail, flush;
  logic [WW-1:0] warm_cnt;
  logic [DW-1:0] rct_ref;
  logic [RW-1:0] rct_cnt, rct_nxt;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop, drop;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= WARMUP;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    load_ref  = 1'b0;
    run_step  = 1'b0;
    clr_cnt   = 1'b0;
    push_req  = 1'b0;
    warm_inc  = 1'b0;
    case (cur_state)
      WARMUP: begin
        if (in_valid) begin
          if (warm_cnt == WW'(WARMUP_N - 1)) begin
            load_ref  = 1'b1;
            nxt_state = RUN;
          end else begin
            warm_inc = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          run_step = 1'b1;
          if (rct_fail || apt_fail) nxt_state = FAULT;
          else                      push_req  = 1'b1;
        end
      end
      FAULT: begin
        if (clear_alarm) begin
          clr_cnt   = 1'b1;
          nxt_state = WARMUP;
        end
      end
      default: nxt_state = WARMUP;
    endcase
  end

  assign state = cur_state;
  assign flush = (cur_state == FAULT);

  always_ff @(posedge clk) begin
    if (rst || clr_cnt || load_ref) warm_cnt <= '0;
    else if (warm_inc)              warm_cnt <= warm_cnt + WW'(1);
  end

  // Repetition count test against the previous accepted sample.
  assign rct_nxt  = (in_data == rct_ref) ? rct_cnt + RW'(1) : RW'(1);
  assign rct_fail = (rct_nxt == RW'(RCT_CUTOFF));

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      rct_ref <= '0;
      rct_cnt <= '0;
    end else if (load_ref || run_step) begin
      rct_ref <= in_data;
      rct_cnt <= load_ref ? RW'(1) : rct_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt)            alarm_rct <= 1'b0;
    else if (run_step && rct_fail) alarm_rct <= 1'b1;
  end

`ifdef RNG_HEALTH_APT_EN
  localparam int PW = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
  localparam int NW = $clog2(APT_CUTOFF + 1);

  logic [DW-1:0] apt_ref;
  logic [PW-1:0] win_pos;
  logic [NW-1:0] apt_cnt, apt_nxt;
  logic          alarm_apt_r;

  // win_pos == 0 marks the first sample of a fresh window (the new reference).
  always_comb begin
    apt_nxt = apt_cnt;
    if (win_pos == '0)           apt_nxt = NW'(1);
    else if (in_data == apt_ref) apt_nxt = apt_cnt + NW'(1);
  end

  assign apt_fail = (apt_nxt == NW'(APT_CUTOFF));

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      apt_ref <= '0;
      win_pos <= '0;
      apt_cnt <= '0;
    end else if (load_ref) begin
      apt_ref <= in_data;
      apt_cnt <= NW'(1);
      win_pos <= PW'(1);
    end else if (run_step) begin
      if (win_pos == '0) apt_ref <= in_data;
      apt_cnt <= apt_nxt;
      win_pos <= win_pos + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt)            alarm_apt_r <= 1'b0;
    else if (run_step && apt_fail) alarm_apt_r <= 1'b1;
  end

  assign alarm_apt = alarm_apt_r;
`else
  assign apt_fail  = 1'b0;
  assign alarm_apt = 1'b0;
`endif

  // Output FIFO: a pop frees the slot for a simultaneous push when full.
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt)                drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_rng_health_monitor.sv
`default_nettype none
// Testbench for rng_health_monitor: directed and random samples checked
// against a queue-based reference model of the health tests and FIFO.
module tb_rng_health_monitor;

  localparam int DW = 16, RCT_CUTOFF = 4, APT_WINDOW = 64, APT_CUTOFF = 8;
  localparam int WARMUP_N = 4, DEPTH = 8;
`ifdef RNG_HEALTH_APT_EN
  localparam bit APT_EN = 1'b1;
`else
  localparam bit APT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, clear_alarm, out_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          out_valid, alarm_rct, alarm_apt;
  logic [7:0]    drop_cnt;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_state, m_warm, m_run, m_drop;
  bit            m_arct, m_aapt;
  logic [DW-1:0] m_last;
  logic [DW-1:0] win_q[$];
  logic [DW-1:0] m_fifo[$];

  rng_health_monitor #(
    .DW(DW), .RCT_CUTOFF(RCT_CUTOFF), .APT_WINDOW(APT_WINDOW),
    .APT_CUTOFF(APT_CUTOFF), .WARMUP_N(WARMUP_N), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .clear_alarm(clear_alarm), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .alarm_rct(alarm_rct), .alarm_apt(alarm_apt),
    .drop_cnt(drop_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit m_pop, push, flush, rf, af;
    int cnt;
    m_pop = (m_fifo.size() > 0) && out_ready;
    if (rst) begin
      m_state = 0; m_warm = 0; m_run = 0; m_drop = 0;
      m_arct = 0; m_aapt = 0;
      win_q.delete(); m_fifo.delete();
      return;
    end
    flush = (m_state == 2);
    push  = 0;
    case (m_state)
      0: if (in_valid) begin
        m_warm++;
        if (m_warm == WARMUP_N) begin
          m_last = in_data; m_run = 1;
          win_q.delete(); win_q.push_back(in_data);
          m_warm = 0; m_state = 1;
        end
      end
      1: if (in_valid) begin
        m_run  = (in_data == m_last) ? m_run + 1 : 1;
        m_last = in_data;
        cnt = 0;
        if (APT_EN) begin
          if (win_q.size() == APT_WINDOW) win_q.delete();
          win_q.push_back(in_data);
          foreach (win_q[i]) if (win_q[i] == win_q[0]) cnt++;
        end
        rf = (m_run >= RCT_CUTOFF);
        af = APT_EN && (cnt >= APT_CUTOFF);
        if (rf || af) begin
          if (rf) m_arct = 1;
          if (af) m_aapt = 1;
          m_state = 2;
        end else push = 1;
      end
      default: if (clear_alarm) begin
        m_arct = 0; m_aapt = 0; m_drop = 0;
        m_warm = 0; m_run = 0; win_q.delete();
        m_state = 0;
      end
    endcase
    if (flush) m_fifo.delete();
    else begin
      if (m_pop) void'(m_fifo.pop_front());
      if (push) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(in_data);
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    check("out_data", 32'(out_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
    check("alarm_rct", 32'(alarm_rct), 32'(m_arct));
    check("alarm_apt", 32'(alarm_apt), 32'(m_aapt));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear_alarm = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Warm-up discards then first pass-through samples
    for (int i = 1; i <= 4; i++) send(DW'(i));
    check("warmup_state", 32'(state), 32'd1);
    check("warmup_no_out", 32'(out_valid), 32'd0);
    send(16'h0531);
    check("first_out", 32'(out_data), 32'h0531);
    send(16'h1A2B);
    check("second_out", 32'(out_data), 32'h1A2B);
    check("run_state", 32'(state), 32'd1);

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      tick();
    end
    out_ready = 1'b1; idle(10);

    // Fill FIFO with ten distinct samples, no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(DW'(16'h0100 + i));
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_drop", 32'(drop_cnt), 32'd2);
    out_ready = 1'b1;
    send(16'h0200);
    check("pop_push_full_drop", 32'(drop_cnt), 32'd2);
    check("pop_push_full_head", 32'(out_data), 32'h0101);
    out_ready = 1'b0;
    send(16'h0201);
    check("still_full_drop", 32'(drop_cnt), 32'd3);
    out_ready = 1'b1; idle(12);

    // Repetition fault on the fourth identical sample
    for (int i = 0; i < 4; i++) send(16'hBEEF);
    check("rct_alarm", 32'(alarm_rct), 32'd1);
    check("rct_state", 32'(state), 32'd2);
    idle(1);
    check("fault_flush", 32'(out_valid), 32'd0);
    send(16'h1111);
    check("fault_no_push", 32'(out_valid), 32'd0);

    // Clear returns to warm-up, then RUN after four discards
    clear_alarm = 1'b1; tick(); clear_alarm = 1'b0;
    check("clear_alarm_rct", 32'(alarm_rct), 32'd0);
    check("clear_drop", 32'(drop_cnt), 32'd0);
    check("clear_state", 32'(state), 32'd0);
    for (int i = 0; i < 3; i++) send(DW'(16'h3000 + i));
    check("warm_3_state", 32'(state), 32'd0);
    send(16'h3003);
    check("warm_4_state", 32'(state), 32'd1);

    // Saturating drop counter
    out_ready = 1'b0;
    for (int i = 0; i < 264; i++) send(DW'(16'h2000 + i));
    check("drop_saturate", 32'(drop_cnt), 32'd255);

    // Reset mid-operation clears everything
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_drop", 32'(drop_cnt), 32'd0);
    out_ready = 1'b1;

    // Proportion test: reference 0x0007 recurring non-adjacently
    send(16'h0A01); send(16'h0A02); send(16'h0A03); send(16'h0007);
    for (int k = 1; k <= 7; k++) begin
      send(DW'(16'h0B00 + k));
      send(16'h0007);
    end
    check("apt_alarm", 32'(alarm_apt), 32'(APT_EN));
    check("apt_state", 32'(state), APT_EN ? 32'd2 : 32'd1);
    clear_alarm = 1'b1; tick(); clear_alarm = 1'b0;
    for (int i = 0; i < 4; i++) send(DW'(16'h4000 + i));

    // Queue five entries ending with a run of three, then reset
    out_ready = 1'b0;
    send(16'h6001); send(16'h6002);
    for (int i = 0; i < 3; i++) send(16'h5555);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h5555);
    send(16'h5555);
    for (int i = 0; i < 3; i++) send(16'h5555);
    check("post_rst_rct_fresh", 32'(alarm_rct), 32'd1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rng_health_monitor.md
RNG_HEALTH_MONITOR -- requirements
Module: rng_health_monitor

Interface
REQ-001 SHALL have parameter DW, default 16: sample width, matching the generator `out` bus.
REQ-002 SHALL have parameter RCT_CUTOFF, default 4: consecutive identical samples that raise a repetition fault.
REQ-003 SHALL have parameter APT_WINDOW, default 64, a power of 2: adaptive-proportion window length.
REQ-004 SHALL have parameter APT_CUTOFF, default 8: occurrences of the window reference that raise a proportion fault.
REQ-005 SHALL have parameter WARMUP_N, default 4: samples discarded after reset or fault clear.
REQ-006 SHALL have parameter DEPTH, default 8, a power of 2: output FIFO depth.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port in_data, input, DW bits: random sample from the generator.
REQ-010 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; there is no input backpressure.
REQ-011 SHALL have port clear_alarm, input, 1 bit: leave FAULT.
REQ-012 SHALL have port out_data, output, DW bits: FIFO head.
REQ-013 SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-015 SHALL have port alarm_rct, output, 1 bit: sticky repetition fault flag.
REQ-016 SHALL have port alarm_apt, output, 1 bit: sticky proportion fault flag.
REQ-017 SHALL have port drop_cnt, output, 8 bits: saturating count of samples dropped because the FIFO was full.
REQ-018 SHALL have port state, output, 2 bits: WARMUP=0, RUN=1, FAULT=2.

Function
REQ-019 SHALL accept a sample only in a cycle with in_valid=1; all counters advance only on accepted samples.
REQ-020 In WARMUP, SHALL discard WARMUP_N accepted samples, use the last discarded sample as the repetition and window reference with both counts at 1, then enter RUN.
REQ-021 Repetition test: for an accepted sample equal to the previous sample, rct_cnt+1; otherwise rct_cnt=1.
REQ-022 SHALL set alarm_rct and enter FAULT when rct_cnt reaches RCT_CUTOFF; the triggering sample SHALL NOT be written to the FIFO.
REQ-023 Proportion test: the first sample of each window is the reference and sets apt_cnt=1; each later equal sample in the window gives apt_cnt+1.
REQ-024 The window SHALL wrap after APT_WINDOW samples, and the next sample SHALL become the new reference.
REQ-025 SHALL set alarm_apt and enter FAULT when apt_cnt reaches APT_CUTOFF; both alarms SHALL set if both cutoffs are reached on the same sample.
REQ-026 In RUN, a sample that passes both tests SHALL be pushed to the FIFO; with the FIFO empty, it SHALL appear on out_data/out_valid the next cycle.
REQ-027 The FIFO SHALL be first-word-fall-through; a pop occurs when out_valid and out_ready are both 1.
REQ-028 FIFO full with no pop in the same cycle: the sample SHALL be dropped and drop_cnt SHALL increment, saturating at 255.
REQ-029 FIFO full with a pop in the same cycle: the push SHALL be accepted and the count SHALL remain DEPTH.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH.
REQ-031 Entering FAULT SHALL flush the FIFO on the next cycle, so out_valid=0; in FAULT, no push occurs.
REQ-032 clear_alarm=1 in FAULT SHALL clear both alarms, rct_cnt, apt_cnt, the window position and drop_cnt, then enter WARMUP.
REQ-033 clear_alarm SHALL be ignored in WARMUP and RUN.

Reset
REQ-034 rst=1 at a clock edge SHALL, from any state and mid-operation, set state=WARMUP, out_valid=0, out_data=0, alarm_rct=0, alarm_apt=0 and drop_cnt=0, empty the FIFO and zero all counters.
REQ-035 Samples presented while rst=1 SHALL be ignored.

Configuration
REQ-036 With RNG_HEALTH_APT_EN defined, the proportion test SHALL be built.
REQ-037 Without RNG_HEALTH_APT_EN, the window logic SHALL be absent, alarm_apt SHALL be tied to 0, and only the repetition test SHALL gate samples.

Verification
REQ-038 Reset, then samples 1..4 followed by 0x0531, 0x1A2B with out_ready=1 -> the first four are dropped, and 0x0531 then 0x1A2B appear one cycle after acceptance; state=1.
REQ-039 In RUN, four consecutive samples 0xBEEF -> alarm_rct=1 on the cycle after the fourth, state=2, out_valid=0 next cycle; the three earlier samples reach the FIFO (defaults).
REQ-040 With RNG_HEALTH_APT_EN, a window whose reference 0x0007 recurs non-adjacently 7 more times in 64 samples -> alarm_apt=1 at the 8th occurrence; undefined -> no alarm.
REQ-041 out_ready=0, 10 distinct samples -> FIFO holds 8, drop_cnt=2; then pop and push in the same cycle while full -> count stays 8, drop_cnt=2.
REQ-042 In FAULT, clear_alarm pulse -> alarms 0, drop_cnt 0, state=0; after 4 discarded samples, state=1.
REQ-043 rst asserted with 5 entries queued and rct_cnt=3 -> next cycle out_valid=0, state=0, all counters 0.
